// File: rtl/elixirchip_es1_spu_op_sll_pipe.sv
// Pipelined logical left shifter. The barrel network is split across
// LATENCY register stages; stage i consumes its own slice of shift-amount
// bits and forwards only the still-unconsumed bits to the next stage, so
// back-to-back beats never share shift state.
module elixirchip_es1_spu_op_sll_pipe #(
  parameter int                    LATENCY    = 2,
  parameter int                    DATA_BITS  = 8,
  parameter int                    MAX_SHIFT  = DATA_BITS,
  parameter int                    SHIFT_BITS = $clog2(MAX_SHIFT),
  parameter logic [DATA_BITS-1:0]  CLEAR_DATA = '0,
  parameter                        DEVICE     = "RTL",
  parameter                        SIMULATION = "false",
  parameter                        DEBUG      = "false"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cke,
  input  logic [SHIFT_BITS-1:0] s_shift,
  input  logic [DATA_BITS-1:0]  s_data,
  input  logic                  s_clear,
  input  logic                  s_valid,
  output logic [DATA_BITS-1:0]  m_data,
  output logic                  m_valid
);

  if (LATENCY < 1) begin : g_bad_latency
    $fatal(1, "elixirchip_es1_spu_op_sll_pipe: LATENCY must be >= 1");
  end
  if (SHIFT_BITS < 1) begin : g_bad_shift_bits
    $fatal(1, "elixirchip_es1_spu_op_sll_pipe: SHIFT_BITS must be >= 1");
  end

  // shift bits handled per stage; trailing stages may get none (pure delay)
  localparam int STEP = (SHIFT_BITS + LATENCY - 1) / LATENCY;

  // mask of the shift bits a given stage applies
  function automatic logic [SHIFT_BITS-1:0] stage_mask(input int stg);
    logic [SHIFT_BITS-1:0] m;
    m = '0;
    for (int b = 0; b < SHIFT_BITS; b++)
      m[b] = (b >= stg * STEP) && (b < (stg + 1) * STEP);
    return m;
  endfunction

  // index i = value entering stage i; index LATENCY = final output
  logic [LATENCY:0][DATA_BITS-1:0]    data_pipe;
  logic [LATENCY-1:0][SHIFT_BITS-1:0] shift_pipe;
  logic [LATENCY:0]                   vld_pipe;
  logic [LATENCY:0]                   clr_pipe;
  logic [LATENCY:1]                   vld_q;
  logic [LATENCY:1]                   clr_q;

  assign data_pipe[0]  = s_data;
  assign shift_pipe[0] = s_shift;
  assign vld_pipe      = {vld_q, s_valid};
  assign clr_pipe      = {clr_q, s_clear};

  // valid/clear flags advance every enabled cycle regardless of beat content
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      clr_q <= '0;
    end else if (cke) begin
      vld_q <= vld_pipe[LATENCY-1:0];
      clr_q <= clr_pipe[LATENCY-1:0];
    end
  end

  for (genvar i = 0; i < LATENCY; i++) begin : g_stage
    localparam logic [SHIFT_BITS-1:0] MASK = stage_mask(i);
    localparam bit                    LAST = (i == LATENCY - 1);

    logic [SHIFT_BITS-1:0] amt;
    logic [DATA_BITS-1:0]  shifted;
    logic [DATA_BITS-1:0]  data_q;
    logic                  load;

    assign amt     = shift_pipe[i] & MASK;
    assign shifted = data_pipe[i] << amt;
    assign load    = vld_pipe[i] | clr_pipe[i];

    // data moves only with a real beat; the last stage substitutes CLEAR_DATA
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)
        data_q <= '0;
      else if (cke && load)
        data_q <= (LAST && clr_pipe[i]) ? CLEAR_DATA : shifted;
    end

    assign data_pipe[i+1] = data_q;

    if (!LAST) begin : g_shift_reg
      logic [SHIFT_BITS-1:0] shift_q;

      // carry only the bits later stages still have to apply
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)
          shift_q <= '0;
        else if (cke && load)
          shift_q <= shift_pipe[i] & ~MASK;
      end

      assign shift_pipe[i+1] = shift_q;
    end
  end

  assign m_data  = data_pipe[LATENCY];
  assign m_valid = vld_pipe[LATENCY];

endmodule

// File: tb/tb_elixirchip_es1_spu_op_sll_pipe.sv
// Bench for the pipelined left shifter: one 8-bit LATENCY=2 instance for the
// directed scenarios plus 32-bit instances at LATENCY 1/2/3/5 for the random
// sweep, each with its own expected-result queue.
module tb_elixirchip_es1_spu_op_sll_pipe;

  typedef struct {
    logic [31:0] d;
    logic        v;
    int unsigned due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, cke;
  logic [31:0] a_data, b_data;
  logic [7:0]  a_shift, b_shift;
  logic        a_valid, a_clear, b_valid, b_clear;
  int          checks = 0;
  int          fails  = 0;

  function automatic int lat_of(input int k);
    case (k)
      0: return 2;
      1: return 1;
      2: return 2;
      3: return 3;
      default: return 5;
    endcase
  endfunction

  // instance 0 is driven by a_*, the sweep instances by b_*
  for (genvar gi = 0; gi < 5; gi++) begin : g_dut
    localparam int L  = lat_of(gi);
    localparam int DW = (gi == 0) ? 8 : 32;
    localparam int SB = (gi == 0) ? 4 : 5;
    localparam logic [DW-1:0] CD = (gi == 0) ? DW'(32'h5A) : '0;

    logic [DW-1:0] sd, md;
    logic [SB-1:0] ss;
    logic          sv, sc, mv;

    assign sd = (gi == 0) ? a_data[DW-1:0]  : b_data[DW-1:0];
    assign ss = (gi == 0) ? a_shift[SB-1:0] : b_shift[SB-1:0];
    assign sv = (gi == 0) ? a_valid : b_valid;
    assign sc = (gi == 0) ? a_clear : b_clear;

    elixirchip_es1_spu_op_sll_pipe #(
      .LATENCY(L), .DATA_BITS(DW), .SHIFT_BITS(SB), .CLEAR_DATA(CD)
    ) u_dut (
      .clk(clk), .reset(rst_n), .cke(cke),
      .s_shift(ss), .s_data(sd), .s_clear(sc), .s_valid(sv),
      .m_data(md), .m_valid(mv)
    );

    exp_t          q[$];
    int unsigned   ecnt = 0;
    bit            newe = 1'b0;
    logic [DW-1:0] last = '0;

    always @(negedge rst_n) begin
      q.delete();
      newe = 1'b0;
      last = '0;
    end

    // record the expected result of every beat accepted on an enabled edge
    always @(posedge clk) begin
      exp_t        e;
      logic [63:0] wide;
      if (rst_n && cke) begin
        ecnt++;
        newe = 1'b1;
        if (sv || sc) begin
          wide  = 64'(sd) << ss;
          e.d   = sc ? 32'(CD) : 32'(wide[DW-1:0]);
          e.v   = sv;
          e.due = ecnt + L - 1;
          q.push_back(e);
        end
      end
    end

    // after each enabled edge: either the due beat or an idle, held output
    always @(negedge clk) begin
      exp_t e;
      if (newe) begin
        newe = 1'b0;
        checks++;
        if (q.size() > 0 && q[0].due == ecnt) begin
          e = q.pop_front();
          if (md !== e.d[DW-1:0] || mv !== e.v) begin
            fails++;
            $display("FAIL dut%0d_beat: m_data=%h m_valid=%b want %h/%b", gi, md, mv, e.d[DW-1:0], e.v);
          end
          last = e.d[DW-1:0];
        end else if (mv !== 1'b0 || md !== last) begin
          fails++;
          $display("FAIL dut%0d_idle: m_data=%h m_valid=%b want %h/0", gi, md, mv, last);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic c, input logic [7:0] d, input logic [7:0] s);
    a_valid = v;
    a_clear = c;
    a_data  = {24'h0, d};
    a_shift = s;
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (g_dut[0].md !== 8'h00 || g_dut[0].mv !== 1'b0) begin
      fails++;
      $display("FAIL reset_main: m_data=%h m_valid=%b want 00/0", g_dut[0].md, g_dut[0].mv);
    end
    checks++;
    if (g_dut[4].md !== 32'h0 || g_dut[4].mv !== 1'b0) begin
      fails++;
      $display("FAIL reset_lat5: m_data=%h m_valid=%b want 0/0", g_dut[4].md, g_dut[4].mv);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [7:0] want [4];
    logic [7:0] sh   [4];
    want = '{8'h81, 8'h02, 8'h08, 8'h80};
    sh   = '{8'd0, 8'd1, 8'd3, 8'd7};
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 8'h81, sh[k]);
      if (k > 0) begin
        checks++;
        if (g_dut[0].md !== want[k-1] || g_dut[0].mv !== 1'b1) begin
          fails++;
          $display("FAIL basic_%0d: m_data=%h m_valid=%b want %h/1", k - 1, g_dut[0].md, g_dut[0].mv, want[k-1]);
        end
      end
    end
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    checks++;
    if (g_dut[0].md !== want[3] || g_dut[0].mv !== 1'b1) begin
      fails++;
      $display("FAIL basic_3: m_data=%h m_valid=%b want %h/1", g_dut[0].md, g_dut[0].mv, want[3]);
    end
    repeat (2) drive(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_overflow;
    logic [7:0] sh   [3];
    logic [7:0] want [3];
    sh   = '{8'd8, 8'd15, 8'd7};
    want = '{8'h00, 8'h00, 8'h80};
    for (int k = 0; k < 4; k++) begin
      if (k < 3) drive(1'b1, 1'b0, 8'hFF, sh[k]);
      else       drive(1'b0, 1'b0, 8'h00, 8'h00);
      if (k > 0) begin
        checks++;
        if (g_dut[0].md !== want[k-1] || g_dut[0].mv !== 1'b1) begin
          fails++;
          $display("FAIL overflow_sh%0d: m_data=%h m_valid=%b want %h/1", sh[k-1], g_dut[0].md, g_dut[0].mv, want[k-1]);
        end
      end
    end
    drive(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_clear;
    drive(1'b0, 1'b1, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 8'h01, 8'h02);
    checks++;
    if (g_dut[0].md !== 8'h5A || g_dut[0].mv !== 1'b0) begin
      fails++;
      $display("FAIL clear_only: m_data=%h m_valid=%b want 5a/0", g_dut[0].md, g_dut[0].mv);
    end
    drive(1'b1, 1'b1, 8'h33, 8'h01);
    checks++;
    if (g_dut[0].md !== 8'h04 || g_dut[0].mv !== 1'b1) begin
      fails++;
      $display("FAIL clear_then_beat: m_data=%h m_valid=%b want 04/1", g_dut[0].md, g_dut[0].mv);
    end
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    checks++;
    if (g_dut[0].md !== 8'h5A || g_dut[0].mv !== 1'b1) begin
      fails++;
      $display("FAIL clear_and_valid: m_data=%h m_valid=%b want 5a/1", g_dut[0].md, g_dut[0].mv);
    end
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    checks++;
    if (g_dut[0].md !== 8'h5A || g_dut[0].mv !== 1'b0) begin
      fails++;
      $display("FAIL clear_hold: m_data=%h m_valid=%b want 5a/0", g_dut[0].md, g_dut[0].mv);
    end
  endtask

  task automatic test_cke_stall;
    logic [7:0] snap_d;
    logic       snap_v;
    drive(1'b1, 1'b0, 8'h03, 8'h01);
    cke = 1'b0;
    a_valid = 1'b0;
    snap_d = g_dut[0].md;
    snap_v = g_dut[0].mv;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (g_dut[0].md !== snap_d || g_dut[0].mv !== snap_v) begin
        fails++;
        $display("FAIL stall_hold: m_data=%h m_valid=%b want %h/%b", g_dut[0].md, g_dut[0].mv, snap_d, snap_v);
      end
    end
    cke = 1'b1;
    @(negedge clk);
    checks++;
    if (g_dut[0].md !== 8'h06 || g_dut[0].mv !== 1'b1) begin
      fails++;
      $display("FAIL stall_resume: m_data=%h m_valid=%b want 06/1", g_dut[0].md, g_dut[0].mv);
    end
    // m_valid must stay asserted while the enable is low
    drive(1'b1, 1'b0, 8'h05, 8'h02);
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    cke = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (g_dut[0].md !== 8'h14 || g_dut[0].mv !== 1'b1) begin
        fails++;
        $display("FAIL stall_valid_held: m_data=%h m_valid=%b want 14/1", g_dut[0].md, g_dut[0].mv);
      end
    end
    cke = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    checks++;
    if (g_dut[0].md !== 8'h14 || g_dut[0].mv !== 1'b0) begin
      fails++;
      $display("FAIL stall_release: m_data=%h m_valid=%b want 14/0", g_dut[0].md, g_dut[0].mv);
    end
  endtask

  task automatic test_reset_mid;
    int pulses;
    drive(1'b1, 1'b0, 8'h11, 8'h01);
    drive(1'b1, 1'b0, 8'h22, 8'h02);
    a_valid = 1'b1;
    a_data  = 32'h33;
    a_shift = 8'h03;
    @(posedge clk);
    #2;
    a_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    checks++;
    if (g_dut[0].md !== 8'h00 || g_dut[0].mv !== 1'b0) begin
      fails++;
      $display("FAIL reset_async: m_data=%h m_valid=%b want 00/0", g_dut[0].md, g_dut[0].mv);
    end
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (g_dut[0].mv) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      fails++;
      $display("FAIL reset_stale: m_valid pulses=%0d want 0", pulses);
    end
  endtask

  task automatic test_sweep;
    int   acc, pulses, cyc;
    logic ck;
    acc = 0; pulses = 0; cyc = 0;
    while (acc < 1000 && cyc < 5000) begin
      ck      = ($urandom_range(0, 9) != 0);
      cke     = ck;
      b_valid = ($urandom_range(0, 9) != 0);
      b_data  = $urandom;
      b_shift = 8'($urandom_range(0, 31));
      @(negedge clk);
      cyc++;
      if (ck) begin
        if (b_valid) acc++;
        if (g_dut[4].mv) pulses++;
      end
    end
    cke     = 1'b1;
    b_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (g_dut[4].mv) pulses++;
    end
    checks++;
    if (acc < 1000) begin
      fails++;
      $display("FAIL sweep_budget: accepted=%0d want 1000", acc);
    end
    checks++;
    if (pulses != acc) begin
      fails++;
      $display("FAIL sweep_pulse_count: m_valid pulses=%0d want %0d", pulses, acc);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    cke     = 1'b1;
    a_data  = '0; a_shift = '0; a_valid = 1'b0; a_clear = 1'b0;
    b_data  = '0; b_shift = '0; b_valid = 1'b0; b_clear = 1'b0;
    test_reset;
    test_basic;
    test_overflow;
    test_clear;
    test_cke_stall;
    test_reset_mid;
    test_sweep;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
